// File: rtl/stopwatch_display_driver.sv
// stopwatch_display_driver: converts a centisecond count to MM:SS.cc BCD and scans it onto
// a multiplexed active-low seven-segment display.
module stopwatch_display_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int MAX_CS = 599999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] time_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        ovf,
  output logic        upd
);
  localparam logic [2:0] IDLE = 3'd0, MIN = 3'd1, SEC = 3'd2, DM = 3'd3, DS = 3'd4, DC = 3'd5, COMMIT = 3'd6;
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  logic [2:0] state, idx, idx_n;
  logic [19:0] r;
  logic [6:0] m, s, c;
  logic [3:0] mt, mo, st, so, ct, co, dig_n;
  logic ovf_pending, wrap;
  logic [CW-1:0] cnt;
  logic [23:0] disp, disp_n;
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'b1000000;
      4'd1: decode = 7'b1111001;
      4'd2: decode = 7'b0100100;
      4'd3: decode = 7'b0110000;
      4'd4: decode = 7'b0011001;
      4'd5: decode = 7'b0010010;
      4'd6: decode = 7'b0000010;
      4'd7: decode = 7'b1111000;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      r <= '0;
      {m, s, c} <= '0;
      {mt, mo, st, so, ct, co} <= '0;
      ovf_pending <= 1'b0;
    end else
      case (state)
        IDLE: begin
          r <= time_in > 27'(MAX_CS) ? 20'(MAX_CS) : time_in[19:0];
          ovf_pending <= time_in > 27'(MAX_CS);
          {m, s} <= '0;
          {mt, st, ct} <= '0;
          state <= MIN;
        end
        MIN: if (r >= 20'd6000) begin
          r <= r - 20'd6000;
          m <= m + 7'd1;
        end else state <= SEC;
        SEC: if (r >= 20'd100) begin
          r <= r - 20'd100;
          s <= s + 7'd1;
        end else begin
          c <= r[6:0];
          state <= DM;
        end
        DM: if (m >= 7'd10) begin
          m <= m - 7'd10;
          mt <= mt + 4'd1;
        end else begin
          mo <= m[3:0];
          state <= DS;
        end
        DS: if (s >= 7'd10) begin
          s <= s - 7'd10;
          st <= st + 4'd1;
        end else begin
          so <= s[3:0];
          state <= DC;
        end
        DC: if (c >= 7'd10) begin
          c <= c - 7'd10;
          ct <= ct + 4'd1;
        end else begin
          co <= c[3:0];
          state <= COMMIT;
        end
        default: state <= IDLE;
      endcase
  // seg/dp are decoded from next-cycle digits so a commit shows up alongside upd
  always_comb begin
    disp_n = state == COMMIT ? {mt, mo, st, so, ct, co} : disp;
    wrap = cnt == LAST;
    idx_n = wrap ? (idx == 3'd5 ? 3'd0 : idx + 3'd1) : idx;
    dig_n = disp_n[{idx_n, 2'b00} +: 4];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      disp <= '0;
      ovf <= 1'b0;
      upd <= 1'b0;
      cnt <= '0;
      idx <= '0;
      an <= 8'hFE;
      seg <= 7'b1000000;
      dp <= 1'b1;
    end else begin
      disp <= disp_n;
      ovf <= state == COMMIT ? ovf_pending : ovf;
      upd <= state == COMMIT;
      cnt <= wrap ? '0 : cnt + CW'(1);
      idx <= idx_n;
      an <= ~(8'd1 << idx_n);
      seg <= decode(dig_n);
      dp <= !(idx_n == 3'd2 || idx_n == 3'd4);
    end
endmodule

// File: tb/tb_stopwatch_display_driver.sv
// tb_stopwatch_display_driver: directed and random conversions checked against an arithmetic
// MM:SS.cc model, with two scan rates observed every cycle.
module tb_stopwatch_display_driver;
  localparam int MAX_CS = 599999;
  logic clk = 1'b0, reset = 1'b1;
  logic [26:0] time_in = '0;
  logic [6:0] seg4, seg1;
  logic dp4, dp1, ovf4, ovf1, upd4, upd1;
  logic [7:0] an4, an1;
  int tests = 0, fails = 0, cyc = 0;
  int shown [6] = '{default: 0};
  logic shown_ovf = 1'b0;
  int exp_d [6];
  logic exp_ovf;
  int exp_lat;
  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  stopwatch_display_driver #(.SCAN_DIV(4)) dut4 (.clk(clk), .reset(reset), .time_in(time_in),
    .seg(seg4), .dp(dp4), .an(an4), .ovf(ovf4), .upd(upd4));
  stopwatch_display_driver #(.SCAN_DIV(1)) dut1 (.clk(clk), .reset(reset), .time_in(time_in),
    .seg(seg1), .dp(dp1), .an(an1), .ovf(ovf1), .upd(upd1));
  always #5 clk = ~clk;
  // clock edges since reset release; the scan position follows directly from it
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic scan_check();
    int i4, i1;
    logic [7:0] e4, e1;
    i4 = (cyc / 4) % 6;
    i1 = cyc % 6;
    e4 = 8'hFF;
    e4[i4] = 1'b0;
    e1 = 8'hFF;
    e1[i1] = 1'b0;
    chk("an4", an4, e4);
    chk("seg4", seg4, segtab[shown[i4]]);
    chk("dp4", dp4, (i4 == 2 || i4 == 4) ? 0 : 1);
    chk("ovf4", ovf4, shown_ovf);
    chk("an1", an1, e1);
    chk("seg1", seg1, segtab[shown[i1]]);
    chk("dp1", dp1, (i1 == 2 || i1 == 4) ? 0 : 1);
    chk("ovf1", ovf1, shown_ovf);
  endtask
  task automatic predict(input logic [26:0] v);
    int t, mm, ss, cc;
    t = v > MAX_CS ? MAX_CS : int'(v);
    mm = t / 6000;
    ss = t / 100 % 60;
    cc = t % 100;
    exp_d = '{cc % 10, cc / 10, ss % 10, ss / 10, mm % 10, mm / 10};
    exp_ovf = v > MAX_CS;
    exp_lat = mm + ss + mm / 10 + ss / 10 + cc / 10 + 7;
  endtask
  // called at a negedge whose next posedge is an IDLE capture; returns on the upd negedge
  task automatic conv(input logic [26:0] v, input logic [26:0] v2, input int chg, input int reps);
    for (int r = 0; r < reps; r++) begin
      predict(v);
      time_in = v;
      for (int i = 1; i <= exp_lat; i++) begin
        @(negedge clk);
        if (r == 0 && i == chg) time_in = v2;
        if (i == exp_lat) begin
          shown = exp_d;
          shown_ovf = exp_ovf;
        end
        chk("upd4", upd4, i == exp_lat);
        chk("upd1", upd1, i == exp_lat);
        scan_check();
      end
    end
  endtask
  initial begin
    logic [26:0] v;
    int sel;
    repeat (3) begin
      @(negedge clk);
      chk("upd4 reset", upd4, 0);
      chk("upd1 reset", upd1, 0);
      scan_check();
    end
    reset = 1'b0;
    conv(27'd0, 27'd0, 0, 4);
    conv(27'd12345, 27'd0, 0, 2);
    conv(27'd599999, 27'd0, 0, 1);
    conv(27'd600000, 27'd0, 0, 2);
    conv(27'h7FFFFFF, 27'd0, 0, 1);
    conv(27'd6000, 27'd0, 2, 1);
    conv(27'd0, 27'd0, 0, 1);
    conv(27'd12345, 27'd0, 0, 1);
    time_in = 27'd599999;
    repeat (5) begin
      @(negedge clk);
      chk("upd4 busy", upd4, 0);
      scan_check();
    end
    #2 reset = 1'b1;
    #1;
    shown = '{default: 0};
    shown_ovf = 1'b0;
    chk("upd4 async", upd4, 0);
    chk("upd1 async", upd1, 0);
    scan_check();
    repeat (2) begin
      @(negedge clk);
      scan_check();
    end
    reset = 1'b0;
    conv(27'd4321, 27'd0, 0, 1);
    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) v = 27'($urandom_range(0, MAX_CS));
      else if (sel == 1) v = 27'($urandom_range(0, 9999));
      else if (sel == 2) v = 27'(MAX_CS - 2 + int'($urandom_range(0, 4)));
      else v = 27'($urandom);
      conv(v, v, 0, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stopwatch_display_driver.md
Name: stopwatch_display_driver

Overview:
- Downstream consumer of the stopwatch timer's 27-bit out_time count, in centiseconds.
- Converts the count to MM:SS.cc BCD with a sequential FSM and latches the result atomically.
- Drives a multiplexed, active-low 8-digit seven-segment display; 6 digits used, anodes 7:6 blanked.
- Free-running: a new conversion starts immediately after each commit.

Parameters:
SCAN_DIV, 100000, clk cycles each digit stays lit before the scan advances (must be >= 1)
MAX_CS, 599999, saturation limit in centiseconds (99:59.99)

Ports:
clk      input   1   system clock
reset    input   1   asynchronous, active-high reset
time_in  input   27  elapsed time in centiseconds (timer out_time)
seg      output  7   segment cathodes {g,f,e,d,c,b,a}, active-low
dp       output  1   decimal point, active-low
an       output  8   digit anodes, active-low, an[0] = rightmost digit
ovf      output  1   high while the displayed value is saturated
upd      output  1   one-cycle pulse when new digits are committed

Behaviour:
- Reset (async, active-high): FSM to IDLE; all digit registers 0; scan counter 0; scan index 0; ovf 0; upd 0; an = 8'hFE; seg = 7'b1000000; dp = 1. Reset mid-conversion aborts it: no upd pulse, and the display registers stay 0.
- Working registers: r (20-bit), m, s, c (7-bit each), BCD pairs mt/mo, st/so, ct/co.
- FSM, one state per cycle unless it loops:
  - IDLE: capture. If time_in > MAX_CS, set r = MAX_CS and latch ovf_pending = 1; else r = time_in and ovf_pending = 0. Clear m and s. Go to MIN.
  - MIN: if r >= 6000, then r -= 6000 and m++, and stay; else go to SEC.
  - SEC: if r >= 100, then r -= 100 and s++, and stay; else c = r and go to DM.
  - DM: split m into tens/ones by subtracting 10 per cycle. The exit cycle writes mo. Go to DS.
  - DS: same split for s, writing st/so. Go to DC.
  - DC: same split for c, writing ct/co. Go to COMMIT.
  - COMMIT: copy all six BCD digits and ovf_pending into the display registers in the same cycle; upd = 1 for this cycle only. Go to IDLE.
- Latency from the IDLE capture to the upd pulse is m + s + mt + st + ct + 7 cycles. Minimum 7 (value 0); maximum 99 + 59 + 9 + 5 + 9 + 7 = 188.
- time_in is sampled only in IDLE. Changes during a conversion do not affect it.
- Display digit map, digit index 0..5: co, ct, so, st, mo, mt.
- Decimal points: dp is low when digit 2 (seconds ones) or digit 4 (minutes ones) is active; otherwise high.
- Leading digits are not blanked.
- Scanner:
  - The counter counts 0..SCAN_DIV-1. On wrap, the index advances 0→1→…→5→0.
  - an is registered: bit[idx] = 0, all other bits 1; an[7:6] are always 1.
  - seg and dp are registered from the committed digit at the current index and update in the same cycle as an.
  - A commit that lands while a digit is active changes seg immediately, with no anode change.
- Seven-segment decode ({g..a}, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10..15 cannot occur; decode them to blank (1111111).
- Arithmetic: all comparisons are unsigned. r never underflows because every subtraction is guarded by its comparison.

Test Plan:
- Zero value: SCAN_DIV=4, reset 3 cycles, time_in=0 → upd pulses 7 cycles after reset release; all digits 0; an sequence FE,FD,FB,F7,EF,DF,FE, each held 4 cycles; seg=1000000 throughout; dp low only at an=FB and an=EF.
- Mixed value: time_in=12345 → upd 16 cycles after capture; digits 02:03.45; seg=0010010 at an=FE, seg=0011001 at an=FD, seg=0110000 at an=FB, seg=0100100 at an=EF; ovf=0.
- Saturation: time_in=599999 → 99:59.99, ovf=0, latency 188 cycles. Then time_in=600000 → 99:59.99, ovf=1. Then time_in=27'h7FFFFFF → 99:59.99, ovf=1.
- Mid-conversion input change: time_in=6000 captured, then changed to 0 two cycles later → the first upd shows 01:00.00, the next upd shows 00:00.00.
- Mid-conversion reset: reset asserted asynchronously mid-clock-period during the MIN loop → outputs take reset values immediately, with no upd pulse; after release the first commit reflects the current time_in.
- Scan wrap with a commit in flight: SCAN_DIV=1 → an changes every cycle, cycling through 6 states. A commit landing on an active digit updates seg that cycle with no glitch on an.
